// File: rtl/fifo_reader_tx.sv
// rtl/fifo_reader_tx.sv - FWFT FIFO reader driving an async serial transmitter
// Pops one word per frame and sends start bit, WIDTH data bits LSB first, stop bit.
module fifo_reader_tx #(
    parameter int WIDTH      = 2,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] head,
    input  logic             empty,
    output logic             pop,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       words_sent
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             pop_q, pop_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             bit_end;

    // Cycle counter counts up and wraps at the bit boundary, so BIT_CYCLES==1 never underflows.
    assign bit_end   = (cyc_q == CYC_LAST);
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cyc_d   = bit_end ? '0 : cyc_q + 1'b1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                tx_d  = 1'b1;
                if (!empty) begin
                    shift_d = head;
                    pop_d   = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop        = pop_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign words_sent = cnt_q;

endmodule

// File: tb/tb_fifo_reader_tx.sv
// tb/tb_fifo_reader_tx.sv - scoreboard bench for fifo_reader_tx
module tb_fifo_reader_tx;
    localparam int W    = 2;
    localparam int BC_S = 4;
    localparam int BC_F = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] head_s, head_f;
    logic         empty_s, empty_f;
    logic         pop_s, tx_s, busy_s;
    logic         pop_f, tx_f, busy_f;
    logic [7:0]   ws_s, ws_f;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int pop_cnt_s = 0;
    int pop_cnt_f = 0;
    int pop_cyc_q[$];
    logic [W-1:0] exp_s[$];
    logic [W-1:0] exp_f[$];
    logic pop_prev_s = 1'b0;
    logic pop_prev_f = 1'b0;

    always #5 clk = ~clk;

    fifo_reader_tx #(.WIDTH(W), .BIT_CYCLES(BC_S)) u_dut (
        .clk(clk), .reset(rst_n), .head(head_s), .empty(empty_s),
        .pop(pop_s), .tx(tx_s), .busy(busy_s), .words_sent(ws_s)
    );

    fifo_reader_tx #(.WIDTH(W), .BIT_CYCLES(BC_F)) u_fast (
        .clk(clk), .reset(rst_n), .head(head_f), .empty(empty_f),
        .pop(pop_f), .tx(tx_f), .busy(busy_f), .words_sent(ws_f)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int inst);
        return (inst == 0) ? tx_s : tx_f;
    endfunction

    function automatic logic get_pop(input int inst);
        return (inst == 0) ? pop_s : pop_f;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_s : busy_f;
    endfunction

    // Captures a whole frame from its first low cycle and compares it against the queued word.
    task automatic frame_monitor(input int inst, input int bc);
        int total;
        int samples;
        int expv;
        int n;
        bit aborted;
        bit have;
        logic [W-1:0] w;
        total = (W + 2) * bc;
        forever begin
            @(negedge clk);
            if (rst_n && get_tx(inst) == 1'b0) begin
                samples = 0;
                n = 1;
                aborted = 1'b0;
                while (n < total) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    samples[n] = get_tx(inst);
                    n++;
                end
                if (!aborted) begin
                    have = 1'b0;
                    w = '0;
                    if (inst == 0 && exp_s.size() > 0) begin
                        w = exp_s.pop_front();
                        have = 1'b1;
                    end else if (inst == 1 && exp_f.size() > 0) begin
                        w = exp_f.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        check(inst == 0 ? "unexpected_frame_s" : "unexpected_frame_f", 1, 0);
                    end else begin
                        expv = 0;
                        for (int i = 0; i < total; i++) begin
                            if (i / bc == 0)           expv[i] = 1'b0;
                            else if (i / bc <= W)      expv[i] = w[i / bc - 1];
                            else                       expv[i] = 1'b1;
                        end
                        check(inst == 0 ? "frame_s" : "frame_f", samples, expv);
                    end
                end
            end
        end
    endtask

    initial frame_monitor(0, BC_S);
    initial frame_monitor(1, BC_F);

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (pop_s) begin
                    check("pop_s_one_cycle", pop_prev_s, 0);
                    pop_cnt_s++;
                    pop_cyc_q.push_back(cyc);
                end
                if (pop_f) begin
                    check("pop_f_one_cycle", pop_prev_f, 0);
                    pop_cnt_f++;
                end
            end
            pop_prev_s = pop_s;
            pop_prev_f = pop_f;
        end
    end

    task automatic wait_pop(input int inst, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_pop(inst) && n < 100);
        if (!get_pop(inst)) check(name, 0, 1);
    endtask

    task automatic wait_idle(input int inst, input string name);
        int n;
        n = 0;
        while (get_busy(inst) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (get_busy(inst)) check(name, 1, 0);
    endtask

    initial begin
        int pc0;
        rst_n   = 1'b0;
        head_s  = 2'd3;
        empty_s = 1'b0;
        head_f  = '0;
        empty_f = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset_tx", tx_s, 1);
            check("reset_pop", pop_s, 0);
            check("reset_busy", busy_s, 0);
            check("reset_words", ws_s, 0);
        end
        empty_s = 1'b1;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_pop", pop_cnt_s, 0);

        // Single word 2'b10
        head_s  = 2'b10;
        empty_s = 1'b0;
        exp_s.push_back(2'b10);
        wait_pop(0, "single_pop_timeout");
        empty_s = 1'b1;
        check("single_busy_at_pop", busy_s, 1);
        check("single_tx_start", tx_s, 0);
        @(negedge clk);
        check("single_pop_width", pop_s, 0);
        wait_idle(0, "single_idle_timeout");
        check("single_words", ws_s, 1);
        check("single_busy_after", busy_s, 0);

        // Back-to-back 1, 2, 3
        repeat (3) @(negedge clk);
        pop_cyc_q.delete();
        exp_s.push_back(2'd1);
        exp_s.push_back(2'd2);
        exp_s.push_back(2'd3);
        head_s  = 2'd1;
        empty_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_pop(0, "b2b_pop_timeout");
            if (k == 0)      head_s = 2'd2;
            else if (k == 1) head_s = 2'd3;
            else             empty_s = 1'b1;
        end
        check("b2b_pop_count", pop_cyc_q.size(), 3);
        if (pop_cyc_q.size() == 3) begin
            check("b2b_spacing_1", pop_cyc_q[1] - pop_cyc_q[0], 17);
            check("b2b_spacing_2", pop_cyc_q[2] - pop_cyc_q[1], 17);
        end
        wait_idle(0, "b2b_idle_timeout");
        check("b2b_words", ws_s, 4);

        // Head and empty change while busy
        repeat (3) @(negedge clk);
        pc0 = pop_cnt_s;
        exp_s.push_back(2'd1);
        head_s  = 2'd1;
        empty_s = 1'b0;
        wait_pop(0, "hchg_pop_timeout");
        empty_s = 1'b1;
        repeat (5) @(negedge clk);
        check("hchg_busy_in_data", busy_s, 1);
        head_s  = 2'd2;
        empty_s = 1'b0;
        repeat (6) @(negedge clk);
        empty_s = 1'b1;
        wait_idle(0, "hchg_idle_timeout");
        repeat (3) @(negedge clk);
        check("hchg_single_pop", pop_cnt_s - pc0, 1);
        check("hchg_words", ws_s, 5);

        // Reset in the middle of DATA for word 3
        head_s  = 2'd3;
        empty_s = 1'b0;
        wait_pop(0, "rst_pop_timeout");
        empty_s = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_busy_before", busy_s, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_now", tx_s, 1);
        check("rst_busy_now", busy_s, 0);
        check("rst_words_now", ws_s, 0);
        check("rst_pop_now", pop_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("rst_after_tx_idle", tx_s, 1);
            check("rst_after_busy", busy_s, 0);
        end
        check("rst_no_retransmit_pop", pop_cnt_s, 6);

        // Fast mode: 256 words, words_sent wraps
        for (int i = 0; i < 256; i++) exp_f.push_back(W'(i));
        head_f  = '0;
        empty_f = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wait_pop(1, "fast_pop_timeout");
            if (i == 1)   check("fast_words_1", ws_f, 1);
            if (i == 255) check("fast_words_255", ws_f, 255);
            if (i < 255) head_f = W'(i + 1);
            else         empty_f = 1'b1;
        end
        wait_idle(1, "fast_idle_timeout");
        check("fast_words_wrap", ws_f, 0);
        check("fast_pop_count", pop_cnt_f, 256);

        repeat (10) @(negedge clk);
        check("slow_frames_left", exp_s.size(), 0);
        check("fast_frames_left", exp_f.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
